// File: rtl/sr_pipe_pkg.sv
// sr_pipe_pkg: shared constants and helpers for the right-shift pipeline.
//   DATA_W / SHAMT_W / TAG_W : default operand, shift-amount and tag widths
//   shift_op_e               : ALU shift-op encodings (SLL/SRL/SRA)
//   fill_bit()               : bit shifted into vacated MSBs
package sr_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 4;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_op_e;

  // Arithmetic shifts replicate the sign bit; logical shifts fill with zero.
  function automatic logic fill_bit(input logic arith, input logic msb);
    return arith & msb;
  endfunction

endpackage

// File: rtl/sr_pipe_stage.sv
// sr_pipe_stage: one registered layer of the right barrel shifter.
// The layer shifts right by DIST when bit log2(DIST) of the carried shift
// amount is set, filling the vacated MSBs with the carried fill bit, and
// registers the result together with valid, shamt, fill and tag.
//   clock, reset_n          : clock, asynchronous active-low reset
//   up_valid/up_data/...    : contents of the previous stage (or the input)
//   down_adv                : downstream stage is able to take our contents
//   adv                     : this stage loads on the next edge
//   valid/data/shamt/fill/tag : registered stage contents
module sr_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAGW  = 4,
  parameter int DIST  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_shamt,
  input  logic             up_fill,
  input  logic [TAGW-1:0]  up_tag,
  input  logic             down_adv,
  output logic             adv,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   shamt,
  output logic             fill,
  output logic [TAGW-1:0]  tag
);

  localparam int SEL = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  // Conditional shift-by-DIST layer with fill-bit insertion.
  always_comb begin
    shifted = up_data;
    if (up_shamt[SEL]) begin
      shifted = {{DIST{up_fill}}, up_data[WIDTH-1:DIST]};
    end else begin
      shifted = up_data;
    end
  end

  // An empty stage always accepts, which is what collapses bubbles.
  assign adv = ~valid | down_adv;

  // Stage registers: load only when advancing, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= {WIDTH{1'b0}};
      shamt <= {SHW{1'b0}};
      fill  <= 1'b0;
      tag   <= {TAGW{1'b0}};
    end else if (adv) begin
      valid <= up_valid;
      data  <= shifted;
      shamt <= up_shamt;
      fill  <= up_fill;
      tag   <= up_tag;
    end else begin
      valid <= valid;
      data  <= data;
      shamt <= shamt;
      fill  <= fill;
      tag   <= tag;
    end
  end

endmodule

// File: rtl/sr_pipe.sv
// sr_pipe: pipelined right barrel shifter (SRL/SRA), one register stage per
// shift-amount bit, valid/ready on both sides, 1 op/cycle with backpressure.
//   clock, reset_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready              : input handshake
//   in_data/in_shamt/in_arith/in_tag : operand, amount, 1=sign fill, tag
//   out_valid/out_ready            : output handshake
//   out_data/out_tag               : result and its tag (straight from last stage)
//   empty                          : no op held in any stage
module sr_pipe
  import sr_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHAMT_W,
  parameter int TAGW  = TAG_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             empty
);

  localparam int NSTG = SHW;

  // Index 0 is the pipeline input; index k is the output of stage k.
  logic             vld   [0:NSTG];
  logic [WIDTH-1:0] dat   [0:NSTG];
  logic [SHW-1:0]   amt   [0:NSTG];
  logic             fil   [0:NSTG];
  logic [TAGW-1:0]  tg    [0:NSTG];
  // adv[k] is stage k's load enable; adv[NSTG+1] is the consumer.
  logic             adv   [1:NSTG+1];
  logic             any_valid;

  assign vld[0] = in_valid;
  assign dat[0] = in_data;
  assign amt[0] = in_shamt;
  assign fil[0] = fill_bit(in_arith, in_data[WIDTH-1]);
  assign tg[0]  = in_tag;

  assign adv[NSTG+1] = out_ready;

  for (genvar k = 1; k <= NSTG; k++) begin : g_stage
    sr_pipe_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .TAGW  (TAGW),
      .DIST  (1 << (k - 1))
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .up_valid (vld[k-1]),
      .up_data  (dat[k-1]),
      .up_shamt (amt[k-1]),
      .up_fill  (fil[k-1]),
      .up_tag   (tg[k-1]),
      .down_adv (adv[k+1]),
      .adv      (adv[k]),
      .valid    (vld[k]),
      .data     (dat[k]),
      .shamt    (amt[k]),
      .fill     (fil[k]),
      .tag      (tg[k])
    );
  end

  // OR of all stage valids for the empty flag.
  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= NSTG; k++) begin
      any_valid = any_valid | vld[k];
    end
  end

  // in_ready depends on out_ready and stage valids only, never on in_valid.
  assign in_ready  = adv[1];
  assign out_valid = vld[NSTG];
  assign out_data  = dat[NSTG];
  assign out_tag   = tg[NSTG];
  assign empty     = ~any_valid;

endmodule

// File: tb/tb_sr_pipe.sv
// tb_sr_pipe: self-checking bench for sr_pipe. A queue of expected results
// (shift computed with >> / >>>) models the pipe as a 5-deep ordered buffer
// whose head becomes visible 5 cycles after acceptance.
module tb_sr_pipe;

  localparam int W = 32;
  localparam int S = 5;
  localparam int T = 4;

  logic         clock     = 1'b0;
  logic         reset_n   = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data   = 32'h0;
  logic [S-1:0] in_shamt  = 5'd0;
  logic         in_arith  = 1'b0;
  logic [T-1:0] in_tag    = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [T-1:0] out_tag;
  logic         empty;

  typedef struct {
    logic [W-1:0] data;
    logic [T-1:0] tag;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_pop    = -100;
  int   popped      = 0;

  sr_pipe dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [S-1:0] sh,
                                             input logic a);
    logic signed [W-1:0] sd;
    sd = d;
    if (a) return sd >>> sh;
    else   return d >> sh;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle: check handshake outputs against the model, score the
  // result if consumed, record the op if accepted, advance to next negedge.
  task automatic tick();
    exp_t e;
    int   due;
    #1;
    due = 0;
    if (exp_q.size() > 0) begin
      due = exp_q[0].acc + 5;
      if (last_pop + 1 > due) due = last_pop + 1;
    end
    chk("in_ready", in_ready, out_ready || (exp_q.size() < 5));
    chk("empty", empty, exp_q.size() == 0);
    chk("out_valid", out_valid, (exp_q.size() > 0) && (cyc >= due));
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_tag", out_tag, e.tag);
      last_pop = cyc;
      popped++;
    end
    if (in_valid && in_ready) begin
      e.data = ref_shift(in_data, in_shamt, in_arith);
      e.tag  = in_tag;
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic randomize_inputs(input logic [T-1:0] tg);
    in_data  = $urandom();
    in_shamt = S'($urandom_range(0, 31));
    in_arith = 1'($urandom_range(0, 1));
    in_tag   = tg;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || !empty) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    chk("drain_empty", empty, 1);
  endtask

  task automatic single(input string name, input logic [W-1:0] d, input logic [S-1:0] sh,
                        input logic a, input logic [T-1:0] tg, input logic [W-1:0] want);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_arith  = a;
    in_tag    = tg;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    // result visible after the 4th edge following the accepting edge
    chk({name, "_latency"}, n, 4);
    chk({name, "_data"}, out_data, want);
    chk({name, "_tag"}, out_tag, tg);
    tick();
  endtask

  initial begin
    int n;
    int p0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed single ops and boundaries
    single("sra4",     32'h80000000, 5'd4,  1'b1, 4'd3, 32'hF8000000);
    single("srl4",     32'h80000000, 5'd4,  1'b0, 4'd3, 32'h08000000);
    single("sra31",    32'h80000001, 5'd31, 1'b1, 4'd5, 32'hFFFFFFFF);
    single("srl31",    32'h80000001, 5'd31, 1'b0, 4'd6, 32'h00000001);
    single("pos_sra31", 32'h7FFFFFFF, 5'd31, 1'b1, 4'd7, 32'h00000000);
    single("sh0_srl",  32'h12345678, 5'd0,  1'b0, 4'd8, 32'h12345678);
    single("sh0_sra",  32'h92345678, 5'd0,  1'b1, 4'd9, 32'h92345678);

    // Streaming: 20 back-to-back random ops, one result per cycle
    drain();
    p0 = popped;
    for (int i = 0; i < 26; i++) begin
      in_valid = (i < 20);
      randomize_inputs(T'(i));
      #1;
      chk("stream_out_valid", out_valid, (i >= 5) && (i < 25));
      tick();
    end
    chk("stream_count", popped - p0, 20);

    // Backpressure: fill with out_ready low, head result must hold
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      randomize_inputs(T'(exp_q.size()));
      if (i >= 5) begin
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, exp_q[0].data);
      end
      tick();
    end
    chk("bp_accepted", exp_q.size(), 5);

    // Release: tags 0..4 emerge in order while streaming resumes
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 6);
      randomize_inputs(T'(5 + i));
      if (i < 5) begin
        #1;
        chk("bp_order_tag", out_tag, i);
        chk("bp_release_ready", in_ready, 1);
      end
      tick();
    end

    // Bubble collapse: 1,0,1,0,1 with out_ready low
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i >= 9) || (i % 2 == 0);
      randomize_inputs(T'(i));
      #1;
      chk("bubble_in_ready", in_ready, i < 9);
      tick();
    end
    chk("bubble_accepted", exp_q.size(), 5);

    // Reset mid-stream with 3 ops in flight
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      randomize_inputs(T'(i + 1));
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("mid_pre_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_empty", empty, 1);
    exp_q.delete();
    last_pop = -100;
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    repeat (8) tick();
    single("post_rst", 32'hC0000000, 5'd2, 1'b1, 4'd12, 32'hF0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_pipe.md
Name: sr_pipe

Overview:
- Pipelined right barrel shifter, one stage per shift-amount bit; the right-shift counterpart to the ALU's combinational left shifter.
- Supports logical (SRL) and arithmetic (SRA) shifts.
- Sits between ALU operand select and writeback.
- valid/ready handshake on both sides; throughput 1 op/cycle with backpressure.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- TAGW, 4, width of the opaque tag carried alongside each op.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  op presented
- in_ready  output  1  op can be accepted this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- in_tag  input  TAGW  carried unchanged to out_tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_tag  output  TAGW  tag of the result
- empty  output  1  no valid op in any stage

Behaviour:
- Reset is asynchronous and active-low on reset_n; single clock domain on clock.
- Five register stages S1..S5. Each stage holds valid, data, remaining shamt bits, fill bit and tag.
- S1 captures in_data after the shift-by-1 layer. Sk applies shift-by-2^(k-1) when shamt[k-1]=1. S5 drives out_data, out_tag and out_valid directly from its registers.
- Fill bit = in_arith & in_data[WIDTH-1], captured at S1. Every vacated MSB in every layer takes this fill bit.
- shamt=0 passes data unchanged. Only shift amounts 0..WIDTH-1 exist.
- Advance rule:
  - adv6 = out_ready.
  - advk = ~Vk | adv(k+1).
  - in_ready = adv1.
  - Stage k loads from stage k-1 when advk is high. Vk becomes V(k-1); V0 = in_valid.
  - When advk is low, stage k holds.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Latency: an op accepted at edge E shows out_valid=1 after edge E+4 (5 cycles) with no stall.
- Full pipeline with out_ready=0: in_ready=0 combinationally. No op is lost or duplicated. Order is strictly FIFO.
- Simultaneous output accept and input accept on a full pipe: all stages shift, and the new op enters S1 in the same edge.
- A stage's data/tag registers are enabled only when it loads. When out_valid=0, out_data is don't-care.
- Asynchronous reset (reset_n=0), including mid-operation:
  - all Vk=0, all data, tag and fill registers cleared to 0;
  - out_valid=0, out_data=0, out_tag=0, empty=1;
  - in_ready=1 as soon as reset is released.
- Ops in flight at reset are discarded.
- empty = ~(V1|V2|V3|V4|V5).
- in_ready and out_valid have no combinational path from in_valid. in_ready depends combinationally on out_ready.

Decomposition:
- Shared package/header alu_defs: WIDTH=32, SHW=5, shift-op encodings (SLL/SRL/SRA).
- Sub-module sr_stage, instantiated five times with parameter DIST = 1, 2, 4, 8, 16.
  - Function: registered mux layer plus valid/advance logic for one stage.
  - sr_pipe itself only chains the stages and derives the fill bit, in_ready and empty.

Test Plan:
- Single op: 0x80000000, shamt=4, arith=1, tag=3 → out_data=0xF8000000, tag=3, exactly 5 cycles after acceptance. Same op with arith=0 → 0x08000000.
- Boundaries:
  - 0x80000001 shamt=31 arith=1 → 0xFFFFFFFF; arith=0 → 0x00000001.
  - 0x7FFFFFFF shamt=31 arith=1 → 0x00000000.
  - 0x12345678 shamt=0 → 0x12345678.
- Streaming: 20 back-to-back random ops, out_ready=1 → one result per cycle, in order. Each result is compared against a reference >> / >>> model.
- Backpressure:
  - in_valid held high with out_ready=0 → exactly 5 ops accepted, then in_ready=0, out_valid=1 holding the first result stable.
  - Release out_ready → results arrive in tag order 0..4, then streaming resumes.
- Bubble collapse: in_valid pattern 1,0,1,0,1 with out_ready=0 → in_ready remains 1 until all 5 stages are filled.
- Reset mid-stream: assert reset_n=0 asynchronously with 3 ops in flight → out_valid and out_data immediately 0, empty=1. After release, the next op's result appears 5 cycles later and no stale result is emitted.
